// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared types and default constants for the parametrised register file.
//   dbg_state_t : state of the debug register scan engine
//   *_DEF       : default width, depth and stack-pointer settings
// ---------------------------------------------------------------------------
package rf_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } dbg_state_t;

   localparam int DATA_W_DEF  = 32;
   localparam int ADDR_W_DEF  = 5;
   localparam int SP_IDX_DEF  = 29;
   localparam int SP_INIT_DEF = 2047;

endpackage

// File: rtl/rf_dbg_scan.sv
// ---------------------------------------------------------------------------
// rf_dbg_scan
// Debug scan engine. It walks every register index from 0 to DEPTH-1 and
// presents each value to a valid/ready consumer, one word per two cycles at
// best (LOAD captures, SEND offers).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : pulse, begins a scan when idle (ignored otherwise)
//   ready        : consumer accepts the word on data/idx
//   rd_idx       : index driven to the register array
//   rd_data      : bypassed register value for rd_idx (from the array)
//   valid        : data/idx hold a word for the consumer
//   idx, data    : captured register index and value
//   busy         : any state other than IDLE
//   done         : one-cycle pulse after the last word is accepted
// ---------------------------------------------------------------------------
module rf_dbg_scan
   import rf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              ready,
   output logic [ADDR_W-1:0] rd_idx,
   input  logic [DATA_W-1:0] rd_data,
   output logic              valid,
   output logic [ADDR_W-1:0] idx,
   output logic [DATA_W-1:0] data,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

   dbg_state_t        state_reg, state_next;
   logic [ADDR_W-1:0] idx_reg, idx_next;
   logic [ADDR_W-1:0] out_idx_reg;
   logic [DATA_W-1:0] data_reg;

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = LOAD;
               idx_next   = '0;
            end
         end
         LOAD: state_next = SEND;
         SEND: begin
            if (ready) begin
               if (idx_reg == LAST_IDX) begin
                  state_next = DONE;
               end else begin
                  idx_next   = idx_reg + 1'b1;
                  state_next = LOAD;
               end
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   // The word is captured only in LOAD, so later writes to the same register
   // cannot disturb what the consumer is looking at during SEND.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_reg    <= '0;
         out_idx_reg <= '0;
      end else if (state_reg == LOAD) begin
         data_reg    <= rd_data;
         out_idx_reg <= idx_reg;
      end
   end

   assign rd_idx = idx_reg;
   assign valid  = (state_reg == SEND);
   assign busy   = (state_reg != IDLE);
   assign done   = (state_reg == DONE);
   assign idx    = out_idx_reg;
   assign data   = data_reg;

endmodule

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
// Parametrised CPU register file: one write port, two registered read ports
// with write-first bypass, optional hardwired-zero r0, a reset-loaded stack
// pointer and a handshake debug scan that streams out every register.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   we, waddr, wdata  : write port
//   re                : read enable shared by both read ports
//   raddr1, raddr2    : read addresses
//   rdata1, rdata2    : registered read data (hold when re=0)
//   dbg_start         : pulse, begin a full register scan
//   dbg_ready         : consumer accepts dbg_data
//   dbg_valid         : dbg_data/dbg_idx valid
//   dbg_idx, dbg_data : scanned register index and value
//   dbg_busy          : scan in progress
//   dbg_done          : one-cycle pulse after the last word is accepted
// ---------------------------------------------------------------------------
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter bit ZERO_R0 = 1'b1,
   parameter int SP_IDX  = SP_IDX_DEF,
   parameter int SP_INIT = SP_INIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   input  logic              dbg_start,
   input  logic              dbg_ready,
   output logic              dbg_valid,
   output logic [ADDR_W-1:0] dbg_idx,
   output logic [DATA_W-1:0] dbg_data,
   output logic              dbg_busy,
   output logic              dbg_done
);

   localparam int DEPTH   = 2 ** ADDR_W;
   localparam int N_RPORT = 3;   // two CPU read ports plus the scan engine

   logic [DATA_W-1:0]               regs [DEPTH];
   logic                            wr_ok;
   logic [DEPTH-1:0]                wr_sel;
   logic [N_RPORT-1:0][ADDR_W-1:0]  rd_addr;
   logic [N_RPORT-1:0][DATA_W-1:0]  rd_val;
   logic [ADDR_W-1:0]               scan_idx;
   logic [DATA_W-1:0]               rdata1_reg, rdata2_reg;

   // A write to r0 is discarded entirely when r0 is hardwired, so it must not
   // feed the bypass path either.
   assign wr_ok = we && !(ZERO_R0 && (waddr == '0));

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_wsel
         assign wr_sel[gi] = wr_ok && (waddr == ADDR_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
               regs[i] <= wdata;
            end
         end
      end
   end

   assign rd_addr[0] = raddr1;
   assign rd_addr[1] = raddr2;
   assign rd_addr[2] = scan_idx;

   // Every reader sees the same write-first view of the array: hardwired
   // zero wins, then a same-cycle write, then the stored value.
   generate
      for (gi = 0; gi < N_RPORT; gi++) begin : g_rport
         assign rd_val[gi] = (ZERO_R0 && (rd_addr[gi] == '0)) ? '0 :
                             (wr_ok && (waddr == rd_addr[gi])) ? wdata :
                             regs[rd_addr[gi]];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata1_reg <= '0;
         rdata2_reg <= '0;
      end else if (re) begin
         rdata1_reg <= rd_val[0];
         rdata2_reg <= rd_val[1];
      end
   end

   assign rdata1 = rdata1_reg;
   assign rdata2 = rdata2_reg;

   rf_dbg_scan #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_scan (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (dbg_start),
      .ready   (dbg_ready),
      .rd_idx  (scan_idx),
      .rd_data (rd_val[2]),
      .valid   (dbg_valid),
      .idx     (dbg_idx),
      .data    (dbg_data),
      .busy    (dbg_busy),
      .done    (dbg_done)
   );

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
// Self-checking bench for reg_file_mp. Two instances share all inputs: one
// with hardwired r0, one without. A behavioural model (register arrays,
// expected read values and a scan tracker) predicts every output.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we, re, dbg_start, dbg_ready;
   logic [4:0]  waddr, raddr1, raddr2;
   logic [31:0] wdata;

   logic [31:0] rdata1, rdata2, dbg_data;
   logic [4:0]  dbg_idx;
   logic        dbg_valid, dbg_busy, dbg_done;

   logic [31:0] rdata1_nz, rdata2_nz, dbg_data_nz;
   logic [4:0]  dbg_idx_nz;
   logic        dbg_valid_nz, dbg_busy_nz, dbg_done_nz;

   always #5 clk = ~clk;

   reg_file_mp #(.ZERO_R0(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1), .rdata2(rdata2),
      .dbg_start(dbg_start), .dbg_ready(dbg_ready), .dbg_valid(dbg_valid),
      .dbg_idx(dbg_idx), .dbg_data(dbg_data), .dbg_busy(dbg_busy),
      .dbg_done(dbg_done)
   );

   reg_file_mp #(.ZERO_R0(1'b0)) u_dut_nz (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1_nz), .rdata2(rdata2_nz),
      .dbg_start(dbg_start), .dbg_ready(dbg_ready), .dbg_valid(dbg_valid_nz),
      .dbg_idx(dbg_idx_nz), .dbg_data(dbg_data_nz), .dbg_busy(dbg_busy_nz),
      .dbg_done(dbg_done_nz)
   );

   int checks = 0;
   int errors = 0;

   // model: index 0 = hardwired-r0 instance, index 1 = plain instance
   logic [31:0] mdl    [2][32];
   logic [31:0] exp_rd [2][2];
   logic        m_busy, m_cap, m_valid, m_done;
   logic [4:0]  m_idx;
   logic [31:0] m_dat;
   int          dut_hs;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pred(input int k, input logic [4:0] a,
                                        input logic w, input logic [4:0] wa,
                                        input logic [31:0] wd);
      if (k == 0 && a == 5'd0) return 32'd0;
      if (w && wa == a && !(k == 0 && wa == 5'd0)) return wd;
      return mdl[k][a];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 32; i++) mdl[k][i] = 32'd0;
         mdl[k][29] = 32'd2047;
         exp_rd[k][0] = 32'd0;
         exp_rd[k][1] = 32'd0;
      end
      m_busy = 0; m_cap = 0; m_valid = 0; m_done = 0; m_idx = 0; m_dat = 0;
   endtask

   task automatic idle_inputs();
      we = 0; waddr = 0; wdata = 0; re = 0; raddr1 = 0; raddr2 = 0;
      dbg_start = 0;
   endtask

   // One clock cycle: latch the inputs, advance the model across the edge,
   // then compare every output 1 time unit after the edge.
   task automatic step();
      logic w, r, st, rdy;
      logic [4:0]  wa, a1, a2;
      logic [31:0] wd;
      w = we; wa = waddr; wd = wdata; r = re; a1 = raddr1; a2 = raddr2;
      st = dbg_start; rdy = dbg_ready;
      if (dbg_valid && dbg_ready) dut_hs++;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (r) begin
            exp_rd[k][0] = pred(k, a1, w, wa, wd);
            exp_rd[k][1] = pred(k, a2, w, wa, wd);
         end
      end
      if (m_done) begin
         m_done = 0;
         m_busy = 0;
      end else if (m_cap) begin
         m_dat   = pred(0, m_idx, w, wa, wd);
         m_cap   = 0;
         m_valid = 1;
      end else if (m_valid && rdy) begin
         $display("scan word idx %0d data %h", m_idx, m_dat);
         m_valid = 0;
         if (m_idx == 5'd31) m_done = 1;
         else begin
            m_idx = m_idx + 5'd1;
            m_cap = 1;
         end
      end else if (!m_busy && st) begin
         m_busy = 1;
         m_idx  = 0;
         m_cap  = 1;
      end
      for (int k = 0; k < 2; k++) begin
         if (w && !(k == 0 && wa == 5'd0)) mdl[k][wa] = wd;
      end
      #1;
      check("rdata1",    rdata1,    exp_rd[0][0]);
      check("rdata2",    rdata2,    exp_rd[0][1]);
      check("rdata1_nz", rdata1_nz, exp_rd[1][0]);
      check("rdata2_nz", rdata2_nz, exp_rd[1][1]);
      check("dbg_valid", dbg_valid, m_valid);
      check("dbg_busy",  dbg_busy,  m_busy);
      check("dbg_done",  dbg_done,  m_done);
      check("dbg_busy_nz", dbg_busy_nz, m_busy);
      if (m_valid) begin
         check("dbg_idx",  dbg_idx,  m_idx);
         check("dbg_data", dbg_data, m_dat);
      end
   endtask

   task automatic run_until_idle(input string tag);
      for (int n = 0; n < 300 && m_busy; n++) step();
      check(tag, m_busy, 1'b0);
   endtask

   initial begin
      int cnt;
      rst_n = 0;
      dbg_ready = 1;
      idle_inputs();
      model_reset();
      dut_hs = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_rdata1", rdata1, 32'd0);
      check("reset_dbg_data", dbg_data, 32'd0);
      check("reset_dbg_idx", dbg_idx, 32'd0);
      check("reset_busy", dbg_busy, 1'b0);
      #3 rst_n = 1;

      // 1: stack pointer reset value
      re = 1; raddr1 = 29; raddr2 = 5;
      step();
      check("t1_sp", rdata1, 32'd2047);
      check("t1_r5", rdata2, 32'd0);

      // 2: write-first bypass, then a normal read from port 2
      we = 1; waddr = 7; wdata = 32'hDEADBEEF; re = 1; raddr1 = 7;
      step();
      check("t2_bypass", rdata1, 32'hDEADBEEF);
      we = 0; raddr1 = 0; raddr2 = 7;
      step();
      check("t2_read2", rdata2, 32'hDEADBEEF);

      // 3: r0 hardwired vs plain
      we = 1; waddr = 0; wdata = 32'h1234; re = 0;
      step();
      we = 0; re = 1; raddr1 = 0;
      step();
      check("t3_r0_zero", rdata1, 32'd0);
      check("t3_r0_plain", rdata1_nz, 32'h1234);

      // 4: preload r[i]=i*3 and scan with ready high
      re = 0;
      for (int i = 0; i < 32; i++) begin
         we = 1; waddr = 5'(i); wdata = 32'(i * 3);
         step();
      end
      idle_inputs();
      dbg_ready = 1; dbg_start = 1; dut_hs = 0;
      step();
      dbg_start = 0;
      cnt = 1;
      while (!dbg_done && cnt < 200) begin
         step();
         cnt++;
      end
      check("t4_done_seen", dbg_done, 1'b1);
      check("t4_done_cycle", 32'(cnt), 32'd65);
      check("t4_handshakes", 32'(dut_hs), 32'd32);
      step();
      check("t4_idle_after", dbg_busy, 1'b0);

      // 5: back-pressure at idx 4 while r4 is overwritten
      dbg_start = 1;
      step();
      dbg_start = 0;
      for (int n = 0; n < 50 && !(m_valid && m_idx == 5'd4); n++) step();
      dbg_ready = 0;
      we = 1; waddr = 4; wdata = 32'h55;
      step();
      we = 0;
      repeat (9) step();
      check("t5_hold_data", dbg_data, 32'd12);
      check("t5_hold_valid", dbg_valid, 1'b1);
      check("t5_hold_idx", dbg_idx, 32'd4);
      dbg_ready = 1;
      for (int n = 0; n < 10 && !(m_valid && m_idx == 5'd5); n++) step();
      check("t5_resume_idx", dbg_idx, 32'd5);
      check("t5_resume_data", dbg_data, 32'd15);
      run_until_idle("t5_scan_end");
      re = 1; raddr1 = 4;
      step();
      check("t5_r4_new", rdata1, 32'h55);

      // 6: asynchronous reset in the middle of a scan
      idle_inputs();
      dbg_start = 1;
      step();
      dbg_start = 0;
      for (int n = 0; n < 50 && !(m_valid && m_idx == 5'd10); n++) step();
      check("t6_reached_10", dbg_idx, 32'd10);
      #2 rst_n = 0;
      #1;
      check("t6_valid_rst", dbg_valid, 1'b0);
      check("t6_busy_rst", dbg_busy, 1'b0);
      check("t6_rdata_rst", rdata1, 32'd0);
      model_reset();
      @(posedge clk);
      #4 rst_n = 1;
      re = 1; raddr1 = 29; raddr2 = 7;
      step();
      check("t6_sp_after", rdata1, 32'd2047);
      check("t6_r7_after", rdata2, 32'd0);
      re = 0; dbg_start = 1;
      step();
      dbg_start = 0;
      for (int n = 0; n < 5 && !m_valid; n++) step();
      check("t6_restart_idx", dbg_idx, 32'd0);
      run_until_idle("t6_scan_end");

      // 7: randomized traffic, scans and back-pressure
      for (int n = 0; n < 600; n++) begin
         we     = 1'($urandom_range(0, 1));
         waddr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         wdata  = $urandom;
         re     = ($urandom_range(0, 3) != 0);
         raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
         raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
         dbg_start = ($urandom_range(0, 15) == 0);
         dbg_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      idle_inputs();
      dbg_ready = 1;
      run_until_idle("t7_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the single-cycle CPU register file.
- Generalised in width and depth, with synchronous reads, write-to-read bypass, an optional hardwired-zero r0 and a reset-loaded stack pointer.
- Adds a handshake debug-scan engine that streams every register out one word at a time, replacing a wide flat check bus.
- Sits between decode (read addresses) and writeback (write port). The debug port connects to the board display/UART path.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
ZERO_R0, 1, 1 = r0 reads as 0 and ignores writes
SP_IDX, 29, index of the register loaded with SP_INIT at reset
SP_INIT, 2047, reset value of r[SP_IDX]; all other registers reset to 0

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
re  in  1  read enable for both read ports
raddr1  in  ADDR_W  read port 1 address
raddr2  in  ADDR_W  read port 2 address
rdata1  out  DATA_W  read port 1 data, registered
rdata2  out  DATA_W  read port 2 data, registered
dbg_start  in  1  pulse: begin a full register scan
dbg_ready  in  1  consumer accepts dbg_data
dbg_valid  out  1  dbg_data/dbg_idx valid
dbg_idx  out  ADDR_W  index of the register on dbg_data
dbg_data  out  DATA_W  scanned register value
dbg_busy  out  1  scan in progress (any state except IDLE)
dbg_done  out  1  one-cycle pulse after the last word is accepted

Interface (already decided): one clock; reset is asynchronous and active-low (rst_n).

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers 0, except r[SP_IDX] = SP_INIT
  - rdata1/2 = 0, dbg_data = 0, dbg_idx = 0
  - dbg_valid/busy/done = 0, FSM = IDLE
  - reset mid-scan aborts the scan; no dbg_done pulse.
- Write: at a posedge with we=1, r[waddr] <= wdata. When ZERO_R0=1 and waddr=0, the write is dropped.
- Read: at a posedge with re=1, rdataN <= r[raddrN]; latency 1 cycle. With re=0, rdataN holds.
- Reads and writes in the same cycle are both performed (no write-blocks-read).
- Bypass: if we=1, re=1 and raddrN==waddr (and not a dropped r0 write), rdataN <= wdata (write-first).
- ZERO_R0=1: raddrN=0 always yields 0.
- Both read ports may address the same register; both get the same value.
- Debug FSM states IDLE, LOAD, SEND, DONE:
  - IDLE: dbg_start=1 -> LOAD with idx=0. dbg_start in any other state is ignored.
  - LOAD: dbg_data <= r[idx], with the same write-first bypass as the read ports; dbg_idx <= idx; -> SEND.
  - SEND: dbg_valid=1. dbg_data and dbg_idx are stable until the handshake (valid&ready).
    - On handshake with idx==DEPTH-1 -> DONE.
    - Otherwise idx++ -> LOAD.
    - A write to the register already captured in SEND does not alter dbg_data.
  - DONE: dbg_done=1 for one cycle -> IDLE.
- Throughput: 1 word per 2 cycles with dbg_ready tied high. A full scan of 32 regs takes 64 cycles from start to the done pulse, plus 1 cycle.
- The scan never stalls CPU reads or writes.

Decomposition:
- Package rf_pkg:
  - dbg_state_t enum (IDLE, LOAD, SEND, DONE)
  - default constants DATA_W_DEF = 32, ADDR_W_DEF = 5, SP_IDX_DEF = 29, SP_INIT_DEF = 2047
- Sub-module rf_dbg_scan:
  - contains the FSM, idx counter and handshake
  - drives an index to the array and receives the bypassed read value
- The array, CPU read/write ports and bypass logic stay in the top module.

Test Plan:
1. Reset, then read r29 and r5 (re=1) -> next cycle rdata1=2047, rdata2=0.
2. we=1, waddr=7, wdata=0xDEADBEEF, with re=1, raddr1=7 in the same cycle -> rdata1=0xDEADBEEF next cycle (bypass). A later read of raddr2=7 -> 0xDEADBEEF.
3. ZERO_R0=1: write 0x1234 to r0, read r0 -> 0. With ZERO_R0=0, the same sequence -> 0x1234.
4. Preload r[i]=i*3, pulse dbg_start, dbg_ready=1 -> 32 handshakes with dbg_idx 0..31 and dbg_data=i*3 (r29 shows 87). dbg_done pulses once, 65 cycles after start.
5. Mid-scan, hold dbg_ready=0 at idx=4 for 10 cycles while writing r4=0x55 -> dbg_data stays at its old value; valid stays high; idx holds. After release, the scan resumes at idx=5.
6. Assert rst_n=0 during a scan at idx=10 -> immediately valid/busy=0 and all registers at reset values. A new dbg_start after release scans from idx=0.
